// File: rtl/md_defs.sv
// Shared definitions for the multiply/divide unit.
//   MD_DATA_WIDTH : default operand / HI / LO width
//   MD_STEPS      : iterative step count (one step per operand bit)
//   md_op_e       : op encodings presented on the op port
//   md_state_e    : control FSM states
package md_defs;

  localparam int MD_DATA_WIDTH = 32;
  localparam int MD_STEPS      = MD_DATA_WIDTH;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10
  } md_state_e;

endpackage

// File: rtl/md_sign_fix.sv
// Conditional two's-complement negation.
//   value  : input word
//   negate : 1 -> result = -value, 0 -> result = value
//   result : output word
// Used both to take operand magnitudes (negate = signed op & sign bit)
// and to apply the final sign correction to product/quotient/remainder.
// The magnitude of the most negative value is itself, read as unsigned.
module md_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic             negate,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = negate ? (~value + 1'b1) : value;
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit owning the architectural HI/LO registers.
//   clk, rst        : clock, synchronous active-high reset
//   start, op, A, B : operation request (sampled only while idle)
//   cancel          : aborts the operation in flight, suppresses a start
//   hi_we, lo_we    : MTHI/MTLO write enables (idle only), data on wdata
//   busy            : operation in flight (CALC or FIX)
//   done            : one-cycle pulse, hi/lo hold the new result
//   hi, lo          : HI/LO registers
// Multiply: 32-step shift-add on magnitudes. Divide: 32-step restoring
// divide on magnitudes with a 33-bit partial remainder. One FIX cycle then
// applies the sign correction and writes hi/lo.
module mul_div_unit
  import md_defs::*;
#(
  parameter int DATA_WIDTH = MD_STEPS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic                  cancel,
  input  logic                  hi_we,
  input  logic                  lo_we,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);

  md_state_e state, state_next;

  md_op_e        op_q;
  logic [CW-1:0] count;
  logic [W:0]    rem;     // multiply: upper product half; divide: partial remainder
  logic [W-1:0]  quo;     // multiply: multiplier shifting out; divide: dividend in, quotient out
  logic [W-1:0]  opnd;    // multiplicand magnitude or divisor magnitude
  logic [W-1:0]  a_raw;   // dividend as presented, returned in hi on divide by zero
  logic          neg_main;
  logic          neg_rem;
  logic          div0_q;
  logic [W-1:0]  hi_q, lo_q;
  logic          done_q;

  // operand magnitudes at latch time
  logic          in_signed;
  logic          in_mul;
  logic [W-1:0]  a_mag_in, b_mag_in;

  assign in_signed = (op == MD_MULT) || (op == MD_DIV);
  assign in_mul    = (op == MD_MULT) || (op == MD_MULTU);

  md_sign_fix #(.WIDTH(W)) u_mag_a (
    .value  (A),
    .negate (in_signed & A[W-1]),
    .result (a_mag_in)
  );

  md_sign_fix #(.WIDTH(W)) u_mag_b (
    .value  (B),
    .negate (in_signed & B[W-1]),
    .result (b_mag_in)
  );

  // single-step datapath
  logic         op_is_mul;
  logic [W-1:0] addend;
  logic [W:0]   mul_sum;
  logic [W:0]   div_shift;
  logic [W:0]   div_trial;
  logic         div_ge;

  assign op_is_mul = (op_q == MD_MULT) || (op_q == MD_MULTU);

  always_comb begin
    addend    = quo[0] ? opnd : '0;
    mul_sum   = rem + {1'b0, addend};
    div_shift = {rem[W-1:0], quo[W-1]};
    div_trial = div_shift - {1'b0, opnd};
    div_ge    = (div_shift >= {1'b0, opnd});
  end

  // sign correction at FIX
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quo_fix, rem_fix;

  md_sign_fix #(.WIDTH(2*W)) u_fix_prod (
    .value  ({rem[W-1:0], quo}),
    .negate (neg_main),
    .result (prod_fix)
  );

  md_sign_fix #(.WIDTH(W)) u_fix_quo (
    .value  (quo),
    .negate (neg_main),
    .result (quo_fix)
  );

  md_sign_fix #(.WIDTH(W)) u_fix_rem (
    .value  (rem[W-1:0]),
    .negate (neg_rem),
    .result (rem_fix)
  );

  // FSM
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: if (start && !cancel) state_next = S_CALC;
      S_CALC: begin
        if (cancel)                  state_next = S_IDLE;
        else if (count == LAST_STEP) state_next = S_FIX;
      end
      S_FIX:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= MD_MULT;
      count    <= '0;
      rem      <= '0;
      quo      <= '0;
      opnd     <= '0;
      a_raw    <= '0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
      div0_q   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start && !cancel) begin
            op_q     <= md_op_e'(op);
            count    <= '0;
            rem      <= '0;
            opnd     <= in_mul ? a_mag_in : b_mag_in;
            quo      <= in_mul ? b_mag_in : a_mag_in;
            a_raw    <= A;
            neg_main <= in_signed & (A[W-1] ^ B[W-1]);
            neg_rem  <= (op == MD_DIV) & A[W-1];
            div0_q   <= !in_mul && (B == '0);
          end
        end
        S_CALC: begin
          count <= count + 1'b1;
          if (op_is_mul) begin
            rem <= {1'b0, mul_sum[W:1]};
            quo <= {mul_sum[0], quo[W-1:1]};
          end else begin
            rem <= div_ge ? div_trial : div_shift;
            quo <= {quo[W-2:0], div_ge};
          end
        end
        default: ;
      endcase
    end
  end

  // HI/LO and done
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state == S_FIX) && !cancel;
      if (state == S_FIX) begin
        if (!cancel) begin
          if (div0_q) begin
            hi_q <= a_raw;
            lo_q <= '1;
          end else if (op_is_mul) begin
            {hi_q, lo_q} <= prod_fix;
          end else begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end
        end
      end else if (state == S_IDLE) begin
        if (hi_we) hi_q <= wdata;
        if (lo_we) lo_q <= wdata;
      end
    end
  end

  assign busy = (state != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] A, B;
  logic        cancel;
  logic        hi_we, lo_we;
  logic [31:0] wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  mul_div_unit #(.DATA_WIDTH(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .A      (A),
    .B      (B),
    .cancel (cancel),
    .hi_we  (hi_we),
    .lo_we  (lo_we),
    .wdata  (wdata),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
    else
      n_pass++;
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [63:0] md_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, q, r;
    longint unsigned ua, ub;
    logic [63:0]     res;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'b0, a};
    ub = {32'b0, b};
    res = '0;
    case (o)
      2'b00: res = sa * sb;
      2'b01: res = ua * ub;
      2'b10: begin
        if (b == 32'b0) res = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 32'b0) res = {a, 32'hFFFF_FFFF};
        else res = {32'(ua % ub), 32'(ua / ub)};
      end
    endcase
    return res;
  endfunction

  int          m_remaining = 0;  // cycles until result lands, 0 when idle
  logic [63:0] m_pend = '0;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic        m_done = 1'b0;

  always @(posedge clk) begin
    m_done = 1'b0;
    if (rst) begin
      m_remaining = 0;
      m_hi = '0;
      m_lo = '0;
    end else if (m_remaining > 0) begin
      if (cancel) m_remaining = 0;
      else begin
        m_remaining--;
        if (m_remaining == 0) begin
          {m_hi, m_lo} = m_pend;
          m_done = 1'b1;
        end
      end
    end else begin
      if (hi_we) m_hi = wdata;
      if (lo_we) m_lo = wdata;
      if (start && !cancel) begin
        m_pend = md_model(op, A, B);
        m_remaining = 33;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_busy", {31'b0, busy}, {31'b0, (m_remaining != 0)});
      check("cyc_done", {31'b0, done}, {31'b0, m_done});
      check("cyc_hi", hi, m_hi);
      check("cyc_lo", lo, m_lo);
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; A = a; B = b;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_done(output int nbusy, output bit got);
    nbusy = 0;
    got   = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (done) got = 1'b1;
      else begin
        if (busy) nbusy++;
        @(posedge clk); #2;
      end
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    int nb;
    bit got;
    @(posedge clk); #2;
    issue(o, a, b);
    wait_done(nb, got);
    check({name, "_done_seen"}, {31'b0, got}, 32'd1);
    check({name, "_busy_cycles"}, nb, 32'd33);
    check({name, "_hi"}, hi, eh);
    check({name, "_lo"}, lo, el);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nb;
    bit got;
    rst = 1'b1; start = 1'b0; op = 2'b00; A = '0; B = '0;
    cancel = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    chk_en = 1'b1;
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult_neg",  2'b00, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op("div_neg",   2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu_zero", 2'b11, 32'd7,         32'd0,         32'd7,         32'hFFFF_FFFF);
    run_op("div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000);
    run_op("mult_min",  2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0);
    run_op("div_negb",  2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD);
    run_op("divu_big",  2'b11, 32'hFFFF_FFFF, 32'h10,        32'hF,         32'h0FFF_FFFF);
    run_op("div_zero",  2'b10, 32'hFFFF_FFF8, 32'd0,         32'hFFFF_FFF8, 32'hFFFF_FFFF);

    // MTHI/MTLO preload, then cancel a DIVU mid-flight
    @(posedge clk); #2; hi_we = 1'b1; wdata = 32'h1234;
    @(posedge clk); #2; hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h5678;
    @(posedge clk); #2; lo_we = 1'b0;
    issue(2'b11, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #2; cancel = 1'b1;
    @(posedge clk); #2; cancel = 1'b0;
    check("cancel_busy", {31'b0, busy}, 32'd0);
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) got = 1'b1;
      @(posedge clk); #2;
    end
    check("cancel_no_done", {31'b0, got}, 32'd0);
    check("cancel_hi", hi, 32'h1234);
    check("cancel_lo", lo, 32'h5678);

    // cancel together with start while idle suppresses the start
    cancel = 1'b1;
    issue(2'b01, 32'd5, 32'd5);
    cancel = 1'b0;
    check("cancel_start_busy", {31'b0, busy}, 32'd0);

    // start and MTHI ignored while busy, then back-to-back start in done cycle
    @(posedge clk); #2;
    issue(2'b01, 32'd3, 32'd4);
    repeat (4) @(posedge clk);
    #2; start = 1'b1; op = 2'b11; A = 32'd9; B = 32'd2; hi_we = 1'b1; wdata = 32'hDEAD;
    @(posedge clk); #2; start = 1'b0; hi_we = 1'b0;
    wait_done(nb, got);
    check("ign_done_seen", {31'b0, got}, 32'd1);
    check("ign_hi", hi, 32'd0);
    check("ign_lo", lo, 32'd12);
    issue(2'b11, 32'd9, 32'd2);
    wait_done(nb, got);
    check("b2b_done_seen", {31'b0, got}, 32'd1);
    check("b2b_busy_cycles", nb, 32'd33);
    check("b2b_hi", hi, 32'd1);
    check("b2b_lo", lo, 32'd4);

    // combined MTHI/MTLO in the same cycle as an accepted start
    @(posedge clk); #2;
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hAAAA_5555;
    issue(2'b01, 32'd2, 32'd3);
    hi_we = 1'b0; lo_we = 1'b0;
    check("wr_start_hi", hi, 32'hAAAA_5555);
    check("wr_start_lo", lo, 32'hAAAA_5555);
    wait_done(nb, got);
    check("wr_start_res_hi", hi, 32'd0);
    check("wr_start_res_lo", lo, 32'd6);

    // reset mid-divide
    @(posedge clk); #2;
    issue(2'b10, 32'd1000, 32'd3);
    repeat (19) @(posedge clk);
    #2; rst = 1'b1;
    @(posedge clk); #2; rst = 1'b0;
    check("rst_mid_busy", {31'b0, busy}, 32'd0);
    check("rst_mid_done", {31'b0, done}, 32'd0);
    check("rst_mid_hi", hi, 32'd0);
    check("rst_mid_lo", lo, 32'd0);
    run_op("after_rst", 2'b01, 32'd2, 32'd3, 32'd0, 32'd6);

    @(posedge clk); #2;
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
